// File: rtl/vid_pkg.sv
// -----------------------------------------------------------------------------
// vid_pkg
//   Shared types and default geometry for the frame-buffer -> filter stream path.
//   Contents:
//     H_RES_DEF / V_RES_DEF  default frame geometry (320x240)
//     PIX_DATA_W             default frame-buffer pixel width
//     fss_state_e            frame_stream_sequencer state encoding
//     pix_beat_t             one stream beat: pixel plus frame markers
// -----------------------------------------------------------------------------
package vid_pkg;

  localparam int H_RES_DEF  = 320;
  localparam int V_RES_DEF  = 240;
  localparam int PIX_DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } fss_state_e;

  // A stream beat: the sop/eop markers travel with the pixel through the FIFO
  // so the head entry alone describes what is on the stream port.
  typedef struct packed {
    logic [PIX_DATA_W-1:0] data;
    logic                  sop;
    logic                  eop;
  } pix_beat_t;

endpackage : vid_pkg

// File: rtl/stream_fifo2.sv
// -----------------------------------------------------------------------------
// stream_fifo2
//   Two-entry FIFO of stream beats. Absorbs the one-clock frame-buffer read
//   latency so the sequencer can keep one pixel per clock flowing.
//   Ports:
//     clk        clock
//     reset      asynchronous, active-high
//     flush      synchronous empty (pointers and count cleared)
//     push       write push_beat this clock (ignored when full and not popping)
//     push_beat  beat to write
//     pop        remove the head this clock (ignored when empty)
//     head_beat  current head entry (meaningful while count != 0)
//     count      number of stored beats, 0..2
// -----------------------------------------------------------------------------
module stream_fifo2
  import vid_pkg::*;
#(
  parameter type beat_t = pix_beat_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  beat_t      push_beat,
  input  logic       pop,
  output beat_t      head_beat,
  output logic [1:0] count
);

  beat_t entry [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  do_push;
  logic  do_pop;

  assign do_pop    = pop && (count != 2'd0);
  assign do_push   = push && ((count != 2'd2) || do_pop);
  assign head_beat = entry[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage is reset (not just the pointers) because the head
      // entry drives the stream data outputs directly and must read 0 at reset.
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entry[wr_ptr] <= push_beat;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule : stream_fifo2

// File: rtl/frame_stream_sequencer.sv
// -----------------------------------------------------------------------------
// frame_stream_sequencer
//   Reads one frame of pixels from the frame-buffer read port in raster order
//   and presents it as a valid/ready stream with sop/eop markers. Menu choice
//   and pitch are latched once per frame, when pixel (0,0) is requested, so
//   downstream filter/kernel selection never changes mid-frame.
//   Ports:
//     clk                 pixel clock (clk_25_vga domain)
//     reset               asynchronous, active-high
//     enable              run frames back to back while high
//     resync              synchronous abort of the current frame
//     menu_choice_in      live menu selection
//     pitch_in            live pitch value
//     rd_addr             frame-buffer read address (data on rd_data 1 clk later)
//     rd_data             frame-buffer q
//     pix_data            stream pixel
//     pix_valid/pix_ready stream handshake, transfer when both high
//     pix_sop/pix_eop     first / last pixel of the frame
//     menu_choice_active  per-frame latched selection
//     pitch_active        per-frame latched pitch
//     frame_count         frames whose eop was accepted (wraps)
//     busy                sequencer not idle
// -----------------------------------------------------------------------------
module frame_stream_sequencer
  import vid_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = PIX_DATA_W,
  parameter int SEL_W   = 3,
  parameter int PITCH_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               resync,
  input  logic [SEL_W-1:0]   menu_choice_in,
  input  logic [PITCH_W-1:0] pitch_in,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_sop,
  output logic               pix_eop,
  output logic [SEL_W-1:0]   menu_choice_active,
  output logic [PITCH_W-1:0] pitch_active,
  output logic [15:0]        frame_count,
  output logic               busy
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

  // Same layout as pix_beat_t, sized by this instance's DATA_W.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
  } beat_t;

  fss_state_e       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  // A read is "in flight" for the clock in which rd_data carries its pixel.
  logic             inflight;
  logic             inflight_sop;
  logic             inflight_eop;

  beat_t            push_beat;
  beat_t            head_beat;
  logic [1:0]       fifo_count;

  logic             pop;
  logic             eop_accept;
  logic             at_first;
  logic             at_last;
  logic [2:0]       occupancy;
  logic             issue;

  // ---------------------------------------------------------------------------
  // Stream side: everything comes from the FIFO head.
  // ---------------------------------------------------------------------------
  assign pix_valid  = (fifo_count != 2'd0);
  assign pix_data   = head_beat.data;
  assign pix_sop    = pix_valid & head_beat.sop;
  assign pix_eop    = pix_valid & head_beat.eop;
  assign pop        = pix_valid & pix_ready;
  assign eop_accept = pop & head_beat.eop;

  // ---------------------------------------------------------------------------
  // Read issue. rd_addr always holds the next raster address; asserting issue
  // commits that address to the RAM this clock, its data is on rd_data next
  // clock and is written into the FIFO at the end of that clock. Counting the
  // in-flight read and this clock's pop keeps the FIFO from overflowing while
  // still allowing one read per clock when the consumer never stalls.
  // ---------------------------------------------------------------------------
  assign at_first = (col == '0) && (row == '0);
  assign at_last  = (col == COL_LAST) && (row == ROW_LAST);

  // NOTE: every signal driven in this block is assigned on every pass, so no
  // latch is inferred.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    issue     = (state == STREAM) && (occupancy < 3'd2);
  end

  assign push_beat = '{data: rd_data, sop: inflight_sop, eop: inflight_eop};

  stream_fifo2 #(
    .beat_t (beat_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (resync),
    .push      (inflight),
    .push_beat (push_beat),
    .pop       (pop),
    .head_beat (head_beat),
    .count     (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Sequencer: state, raster counters, in-flight tracking, config latch and
  // frame counter. rd_addr advances linearly alongside col/row, which keeps it
  // equal to row*H_RES + col without a multiplier.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      busy               <= 1'b0;
      col                <= '0;
      row                <= '0;
      rd_addr            <= '0;
      inflight           <= 1'b0;
      inflight_sop       <= 1'b0;
      inflight_eop       <= 1'b0;
      menu_choice_active <= '0;
      pitch_active       <= '0;
      frame_count        <= '0;
    end else if (resync) begin
      // Abort: the FIFO flushes on the same edge and the pending read is
      // dropped. Latched config and the frame counter are left alone.
      state        <= IDLE;
      busy         <= 1'b0;
      col          <= '0;
      row          <= '0;
      rd_addr      <= '0;
      inflight     <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
    end else begin
      inflight <= issue;

      if (issue) begin
        inflight_sop <= at_first;
        inflight_eop <= at_last;

        if (at_first) begin
          menu_choice_active <= menu_choice_in;
          pitch_active       <= pitch_in;
        end

        if (at_last) begin
          col     <= '0;
          row     <= '0;
          rd_addr <= '0;
        end else begin
          rd_addr <= rd_addr + ADDR_W'(1);
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + ROW_W'(1);
          end else begin
            col <= col + COL_W'(1);
          end
        end
      end

      if (eop_accept) begin
        frame_count <= frame_count + 16'd1;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          if (issue && at_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The last pixel's eop leaving the FIFO ends the frame; enable is
          // only looked at here, so a frame always completes once started.
          if (eop_accept) begin
            if (enable) begin
              state <= STREAM;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : frame_stream_sequencer
